fetch_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 16 +
 rtl/fetch_hold_buf.sv | 40 ++++
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, datapath width and PC constants.
package pipe_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry {pc, inst} buffer that parks a fetched instruction while decode is stalled.
module fetch_hold_buf
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            consume_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            full_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o
);

    logic            full_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;

    // Clear/consume empty the entry; a load captures the response only when not emptying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            pc_q   <= '0;
            inst_q <= NOP_INST;
        end else if (clear_i || consume_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
            pc_q   <= pc_i;
            inst_q <= inst_i;
        end
    end

    assign full_o = full_q;
    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time
// and loads the IF/ID register. Optional FETCH_MISALIGN_CHK_EN aligns redirect targets
// and pulses fetch_misaligned the cycle after a misaligned redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_en,
    input  logic        if_id_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        fetch_misaligned
);
    import pipe_pkg::*;

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] redir_tgt;
    logic            advance, hs, in_wait_rsp;
    logic            deliver_rsp, deliver_buf, buf_load;
    logic            buf_full;
    logic [XLEN-1:0] buf_pc, buf_inst;
    logic            if_id_valid_q;
    logic [XLEN-1:0] if_id_pc_q, if_id_inst_q;

    assign advance     = pc_en & if_id_en;
    assign hs          = imem_req_valid & imem_req_ready;
    assign in_wait_rsp = (state_q == WAIT) & imem_rsp_valid & ~redirect_valid;
    assign deliver_rsp = in_wait_rsp & advance;
    assign buf_load    = in_wait_rsp & ~advance;
    assign deliver_buf = (state_q == HOLD) & buf_full & ~redirect_valid & advance;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    assign redir_tgt = {redirect_pc[31:2], 2'b00};

    // One-cycle flag for a redirect whose target was not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end

    assign fetch_misaligned = misalign_q;
`else
    assign redir_tgt        = redirect_pc;
    assign fetch_misaligned = 1'b0;
`endif

    // Fetch FSM and PC: redirect always wins the PC; a delivered instruction steps it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            if (redirect_valid)                 pc_q <= redir_tgt;
            else if (deliver_rsp || deliver_buf) pc_q <= pc_q + PC_STEP;
            case (state_q)
                IDLE: state_q <= REQ;
                REQ:  if (hs) state_q <= redirect_valid ? DROP : WAIT;
                // A redirect before the response leaves it in flight, so drain it in DROP.
                WAIT: begin
                    if (imem_rsp_valid)      state_q <= (redirect_valid || advance) ? REQ : HOLD;
                    else if (redirect_valid) state_q <= DROP;
                end
                HOLD: if (redirect_valid || advance) state_q <= REQ;
                DROP: if (imem_rsp_valid) state_q <= REQ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;

    fetch_hold_buf u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (buf_load),
        .consume_i (deliver_buf),
        .clear_i   (redirect_valid),
        .pc_i      (pc_q),
        .inst_i    (imem_rsp_data),
        .full_o    (buf_full),
        .pc_o      (buf_pc),
        .inst_o    (buf_inst)
    );

    // IF/ID register: flush beats stall; an enabled cycle without delivery loads a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= NOP_INST;
        end else if (redirect_valid) begin
            if_id_valid_q <= 1'b0;
            if_id_inst_q  <= NOP_INST;
        end else if (if_id_en) begin
            if (deliver_rsp) begin
                if_id_valid_q <= 1'b1;
                if_id_pc_q    <= pc_q;
                if_id_inst_q  <= imem_rsp_data;
            end else if (deliver_buf) begin
                if_id_valid_q <= 1'b1;
                if_id_pc_q    <= buf_pc;
                if_id_inst_q  <= buf_inst;
            end else begin
                if_id_valid_q <= 1'b0;
                if_id_inst_q  <= NOP_INST;
            end
        end
    end

    assign if_id_valid = if_id_valid_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_inst  = if_id_inst_q;

`ifndef SYNTHESIS
    // A response is only legal while a request is outstanding.
    a_rsp_legal: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (state_q == WAIT || state_q == DROP));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected request addresses and IF/ID deliveries are
// queued as stimulus is driven and popped as the DUT produces them.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_en, if_id_en, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_inst;
    logic        fetch_misaligned;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_req[$];
    logic [31:0] exp_ipc[$];
    logic [31:0] exp_ins[$];

    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] snap_pc, snap_inst;
    logic        snap_v;

    fetch_stage #(.RESET_PC(32'h100), .NOP_INST(32'h13)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_inst       (if_id_inst),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hA + ((a - 32'h100) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic deliver);
        exp_req.push_back(a);
        if (deliver) begin
            exp_ipc.push_back(a);
            exp_ins.push_back(mem(a));
        end
    endtask

    // Observes mid-cycle: request handshakes and new IF/ID deliveries against the queues.
    task automatic monitor();
        if (imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) chk("req_unexpected", imem_req_addr, 32'hxxxx_xxxx);
            else                     chk("req_addr", imem_req_addr, exp_req.pop_front());
            pend      = 1'b1;
            pend_addr = imem_req_addr;
        end
        if (if_id_valid && (!prev_v || if_id_pc != prev_pc)) begin
            if (exp_ipc.size() == 0) begin
                chk("ifid_unexpected", if_id_pc, 32'hxxxx_xxxx);
            end else begin
                chk("ifid_pc", if_id_pc, exp_ipc.pop_front());
                chk("ifid_inst", if_id_inst, exp_ins.pop_front());
            end
        end
        prev_v  = if_id_valid;
        prev_pc = if_id_pc;
    endtask

    // One clock: monitor at negedge, then memory answers a handshake in the next cycle.
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        imem_rsp_valid = pend;
        imem_rsp_data  = pend ? mem(pend_addr) : 32'h0;
        pend           = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_tgt;
        logic        exp_mis;
        rst_n = 1'b0; pc_en = 1'b1; if_id_en = 1'b1; redirect_valid = 1'b0;
        redirect_pc = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h100);
        chk("rst_ifid_valid", if_id_valid, 0);
        chk("rst_ifid_pc", if_id_pc, 0);
        chk("rst_ifid_inst", if_id_inst, 32'h13);
        chk("rst_misaligned", fetch_misaligned, 0);

        // First request appears in the second cycle after release.
        rst_n = 1'b1;
        chk("first_cycle_idle", imem_req_valid, 0);
        cyc();
        chk("second_cycle_req", imem_req_valid, 1);
        chk("second_cycle_addr", imem_req_addr, 32'h100);

        // Zero-wait streaming: 0x100 -> A, 0x104 -> B, a bubble between deliveries.
        push_fetch(32'h100, 1'b1);
        push_fetch(32'h104, 1'b1);
        imem_req_ready = 1'b1;
        cyc(); cyc();
        chk("stream_ifid_valid", if_id_valid, 1);
        cyc();
        chk("stream_bubble", if_id_valid, 0);
        chk("stream_next_req", imem_req_valid, 0);
        cyc();
        imem_req_ready = 1'b0;

        // Memory not ready: request held stable.
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_req_valid", imem_req_valid, 1);
            chk("stall_req_addr", imem_req_addr, 32'h108);
        end

        // Response under a 3-cycle decode stall goes to the hold buffer.
        push_fetch(32'h108, 1'b1);
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0; pc_en = 1'b0; if_id_en = 1'b0;
        snap_v = if_id_valid; snap_pc = if_id_pc; snap_inst = if_id_inst;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_ifid_valid", if_id_valid, snap_v);
            chk("hold_ifid_pc", if_id_pc, snap_pc);
            chk("hold_ifid_inst", if_id_inst, snap_inst);
            chk("hold_no_req", imem_req_valid, 0);
        end
        pc_en = 1'b1; if_id_en = 1'b1;
        push_fetch(32'h10C, 1'b1);
        imem_req_ready = 1'b1;
        cyc();
        chk("hold_release_valid", if_id_valid, 1);
        chk("hold_release_inst", if_id_inst, mem(32'h108));
        chk("hold_next_addr", imem_req_addr, 32'h10C);
        cyc();
        imem_req_ready = 1'b0;
        cyc();

        // Redirect during WAIT flushes IF/ID even while stalled and drops the response.
        pc_en = 1'b0; if_id_en = 1'b0;
        push_fetch(32'h110, 1'b0);
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0; pc_en = 1'b1; if_id_en = 1'b1;
        chk("wait_flush_valid", if_id_valid, 0);
        chk("wait_flush_inst", if_id_inst, 32'h13);
        chk("wait_redir_req", imem_req_valid, 1);
        chk("wait_redir_addr", imem_req_addr, 32'h200);

        // Redirect on the handshake cycle -> DROP until the stale response.
        push_fetch(32'h200, 1'b0);
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        cyc();
        redirect_valid = 1'b0; imem_req_ready = 1'b0;
        chk("drop_no_req", imem_req_valid, 0);
        cyc();
        chk("drop_done_req", imem_req_valid, 1);
        chk("drop_done_addr", imem_req_addr, 32'h300);
        chk("drop_no_stale", if_id_valid, 0);
        push_fetch(32'h300, 1'b1);
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        cyc(); cyc();

        // Misaligned redirect target.
`ifdef FETCH_MISALIGN_CHK_EN
        exp_tgt = 32'h400; exp_mis = 1'b1;
`else
        exp_tgt = 32'h402; exp_mis = 1'b0;
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h402;
        cyc();
        redirect_valid = 1'b0;
        chk("misalign_addr", imem_req_addr, exp_tgt);
        chk("misalign_pulse", fetch_misaligned, exp_mis);
        cyc();
        chk("misalign_pulse_end", fetch_misaligned, 0);

        // PC wraps from 0xFFFF_FFFC to 0.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        push_fetch(32'hFFFF_FFFC, 1'b1);
        push_fetch(32'h0, 1'b1);
        imem_req_ready = 1'b1;
        cyc(); cyc(); cyc();
        imem_req_ready = 1'b0;
        cyc(); cyc(); cyc();

        chk("req_queue_left", exp_req.size(), 0);
        chk("ifid_queue_left", exp_ipc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
